// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - data-memory request/response bundle between core MA stage and responder
//
// Purpose: groups the core data-port request (addr/we/rd/wdata) with the responder's
//          reply (rdata/valid/fault).
// Signals:
//   addr   32  byte address
//   we     4   byte write enables
//   rd     1   read request
//   wdata  32  byte-lane-aligned write data
//   rdata  32  read word, registered in the responder
//   valid  1   access complete / nothing pending
//   fault  1   one-cycle pulse for an unmapped access
// Modports: master (core side), slave (responder side).

interface dmem_responder_if;
  logic [31:0] addr;
  logic [3:0]  we;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;
  logic        fault;

  modport master (
    output addr, we, rd, wdata,
    input  rdata, valid, fault
  );

  modport slave (
    input  addr, we, rd, wdata,
    output rdata, valid, fault
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder wrapping a word-wide on-chip RAM
//
// Purpose: serves the core's data-memory port from a 2**DEPTH_LOG2-word RAM mapped at
//          BASE_ADDR, inserting WAIT_STATES stall cycles per access so the core's
//          clock-enable stall path is exercised. Optional MMIO (macro DMEM_MMIO_EN):
//          0xFFFF_FF00 read-only free-running cycle counter, 0xFFFF_FF04 gpio register.
// Ports:
//   i_clk   in   1   clock
//   i_rst   in   1   synchronous reset, active-high
//   ce      in   1   core pipeline advanced at this edge
//   bus     slave    request/response bundle (dmem_responder_if)
//   gpio    out  32  MMIO output register, 0 without DMEM_MMIO_EN

module dmem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         ce,
  dmem_responder_if.slave bus,
  output logic [31:0]  gpio
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int AW      = DEPTH_LOG2 + 2;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [31:0]           mem [DEPTH];

  logic                  req;
  logic                  exec;
  logic                  in_ram;
  logic                  hit_cyc;
  logic                  hit_gpio;
  logic                  mapped;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mmio_q;
  logic [31:0]           rd_word;
  logic                  unused_addr_lsb;

  assign req    = bus.rd | (|bus.we);
  assign in_ram = (bus.addr[31:AW] == BASE_ADDR[31:AW]);
  assign idx    = bus.addr[AW-1:2];

  // The core already lane-shifts, so the byte offset carries no information here.
  assign unused_addr_lsb = ^bus.addr[1:0];

  // Combinational so the core sees the stall in the same cycle the request appears.
  assign bus.valid = !(req && (state != DONE));

  // The access commits at the edge that enters DONE. With no wait states that is
  // the edge leaving IDLE; otherwise WAIT holds for WAIT_STATES cycles, which is why
  // the counter is loaded with WAIT_STATES-1 on leaving IDLE.
  assign exec = ((state == IDLE) && req && NO_WAIT) ||
                ((state == WAIT) && (cnt == 4'd0));

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc;

  assign hit_cyc  = (bus.addr == 32'hFFFF_FF00);
  assign hit_gpio = (bus.addr == 32'hFFFF_FF04);
  assign mmio_q   = hit_cyc ? cyc : gpio;

  always_ff @(posedge i_clk) begin
    if (i_rst) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gpio <= '0;
    end else if (exec && hit_gpio) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.we[n]) gpio[8*n +: 8] <= bus.wdata[8*n +: 8];
      end
    end
  end
`else
  assign hit_cyc  = 1'b0;
  assign hit_gpio = 1'b0;
  assign mmio_q   = '0;
  assign gpio     = '0;
`endif

  // MMIO decodes ahead of the RAM window.
  assign mapped = hit_cyc | hit_gpio | in_ram;

  always_comb begin
    rd_word = '0;
    if (hit_cyc || hit_gpio) rd_word = mmio_q;
    else if (in_ram)         rd_word = mem[idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.rdata <= '0;
      bus.fault <= 1'b0;
    end else begin
      bus.fault <= 1'b0;
      if (exec) begin
        // Pre-write word is returned even for writes; unmapped reads yield 0.
        bus.rdata <= rd_word;
        bus.fault <= !mapped;
      end
      unique case (state)
        IDLE: begin
          if (req) begin
            if (NO_WAIT) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE: begin
          // Without ce the core has not consumed the result; stay put and do not
          // re-execute, however long the stall.
          if (ce || !req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by i_rst so a reset landing on the commit edge abandons the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && exec && in_ram && !hit_cyc && !hit_gpio) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.we[n]) mem[idx][8*n +: 8] <= bus.wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
//
// Purpose: drives two responders (WAIT_STATES=2 and WAIT_STATES=0) through directed
//          read/write/byte-lane/stall/fault/reset sequences with hand-computed results.
// Ports: none (top-level bench).

module tb_dmem_responder;

  logic        i_clk;
  logic        i_rst;
  logic        ce2;
  logic        ce0;
  logic [31:0] gpio2;
  logic [31:0] gpio0;

  int vecs = 0;
  int errs = 0;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.WAIT_STATES(2)) u_dut2 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .ce    (ce2),
    .bus   (bus2.slave),
    .gpio  (gpio2)
  );

  dmem_responder #(.WAIT_STATES(0)) u_dut0 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .ce    (ce0),
    .bus   (bus0.slave),
    .gpio  (gpio0)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int sel, input logic [31:0] a, input logic [3:0] w,
                         input logic r, input logic [31:0] d);
    if (sel == 0) begin
      bus0.addr = a; bus0.we = w; bus0.rd = r; bus0.wdata = d;
    end else begin
      bus2.addr = a; bus2.we = w; bus2.rd = r; bus2.wdata = d;
    end
  endtask

  task automatic set_ce(input int sel, input logic v);
    if (sel == 0) ce0 = v;
    else          ce2 = v;
  endtask

  function automatic logic get_valid(input int sel);
    return (sel == 0) ? bus0.valid : bus2.valid;
  endfunction

  function automatic logic get_fault(input int sel);
    return (sel == 0) ? bus0.fault : bus2.fault;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus0.rdata : bus2.rdata;
  endfunction

  // Called at a negedge. Presents the request, counts valid-low cycles, optionally holds
  // DONE with ce=0 for 'hold' cycles (wdata swapped to d_hold), then releases with ce=1.
  task automatic access(input string tag, input int sel, input logic [31:0] a,
                        input logic [3:0] w, input logic r, input logic [31:0] d,
                        input int hold, input logic [31:0] d_hold,
                        input bit chk_q, input logic [31:0] exp_q,
                        input int exp_lat, input int exp_f, output logic [31:0] q);
    int lat;
    int fcnt;
    set_req(sel, a, w, r, d);
    set_ce(sel, 1'b0);
    lat  = 0;
    fcnt = 0;
    #1;
    while (!get_valid(sel) && lat < 40) begin
      lat++;
      @(negedge i_clk);
      #1;
    end
    q    = get_rdata(sel);
    fcnt = int'(get_fault(sel));
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_q) chk({tag, "_rdata"}, q, exp_q);
    for (int i = 0; i < hold; i++) begin
      set_req(sel, a, w, r, d_hold);
      @(negedge i_clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(get_valid(sel)), 32'd1);
      if (chk_q) chk({tag, "_hold_rdata"}, get_rdata(sel), exp_q);
      fcnt += int'(get_fault(sel));
    end
    chk({tag, "_fault"}, 32'(fcnt), 32'(exp_f));
    set_ce(sel, 1'b1);
    @(negedge i_clk);
    set_ce(sel, 1'b0);
    set_req(sel, 32'd0, 4'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] c1;
    logic [31:0] c2;

    i_rst = 1'b1;
    ce2   = 1'b0;
    ce0   = 1'b0;
    set_req(2, 32'd0, 4'd0, 1'b0, 32'd0);
    set_req(0, 32'd0, 4'd0, 1'b0, 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rst_valid",  32'(bus2.valid), 32'd1);
    chk("rst_rdata",  bus2.rdata, 32'd0);
    chk("rst_fault",  32'(bus2.fault), 32'd0);
    chk("rst_gpio",   gpio2, 32'd0);
    chk("rst_valid0", 32'(bus0.valid), 32'd1);
    @(negedge i_clk);

    // Full-word write then read, WAIT_STATES=2: three stall cycles each.
    access("t1_wr", 2, 32'h0001_0010, 4'hF, 1'b0, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'd0, 3, 0, q);
    access("t1_rd", 2, 32'h0001_0010, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'hDEAD_BEEF, 3, 0, q);

    // Byte lane 1 only; pre-write word returned.
    access("t2_wr", 2, 32'h0001_0010, 4'b0010, 1'b0, 32'h0000_AB00, 0, 0, 1'b1, 32'hDEAD_BEEF, 3, 0, q);
    access("t2_rd", 2, 32'h0001_0010, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'hDEAD_ABEF, 3, 0, q);

    // rd and we together: write wins, old word returned.
    access("rw_wr", 2, 32'h0001_0010, 4'b0001, 1'b1, 32'h0000_0011, 0, 0, 1'b1, 32'hDEAD_ABEF, 3, 0, q);
    access("rw_rd", 2, 32'h0001_0010, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'hDEAD_AB11, 3, 0, q);

    // DONE held 5 cycles with wdata swapped; a re-execution would store 0x2.
    access("t3_wr", 2, 32'h0001_0010, 4'hF, 1'b0, 32'h0000_0001, 5, 32'h0000_0002, 1'b1, 32'hDEAD_AB11, 3, 0, q);
    access("t3_rd", 2, 32'h0001_0010, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'h0000_0001, 3, 0, q);

    // Back-to-back identical reads.
    access("t4_rd_a", 2, 32'h0001_0010, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'h0000_0001, 3, 0, q);
    access("t4_rd_b", 2, 32'h0001_0010, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'h0000_0001, 3, 0, q);

    // Byte offset bits ignored.
    access("lsb_rd", 2, 32'h0001_0013, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'h0000_0001, 3, 0, q);

    // Out of range: fault for one cycle only, write dropped.
    access("t5_pre", 2, 32'h0001_0000, 4'hF, 1'b0, 32'hA5A5_A5A5, 0, 0, 1'b0, 32'd0, 3, 0, q);
    access("t5_wr",  2, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0055, 2, 32'h0000_0055, 1'b1, 32'd0, 3, 1, q);
    access("t5_rd",  2, 32'h0000_0000, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'd0, 3, 1, q);
    access("t5_ram", 2, 32'h0001_0000, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'hA5A5_A5A5, 3, 0, q);

`ifdef DMEM_MMIO_EN
    access("gpio_wr", 2, 32'hFFFF_FF04, 4'hF, 1'b0, 32'h0000_005A, 0, 0, 1'b1, 32'd0, 3, 0, q);
    chk("gpio_out", gpio2, 32'h0000_005A);
    access("gpio_rd", 2, 32'hFFFF_FF04, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'h0000_005A, 3, 0, q);
    access("cyc_rd_a", 2, 32'hFFFF_FF00, 4'h0, 1'b1, 32'd0, 0, 0, 1'b0, 32'd0, 3, 0, c1);
    access("cyc_rd_b", 2, 32'hFFFF_FF00, 4'h0, 1'b1, 32'd0, 0, 0, 1'b0, 32'd0, 3, 0, c2);
    chk("cyc_delta", c2 - c1, 32'd4);
`else
    access("gpio_wr", 2, 32'hFFFF_FF04, 4'hF, 1'b0, 32'h0000_005A, 0, 0, 1'b1, 32'd0, 3, 1, q);
    chk("gpio_out", gpio2, 32'd0);
    access("cyc_rd", 2, 32'hFFFF_FF00, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'd0, 3, 1, c1);
    c2 = c1;
`endif

    // Reset lands on the commit edge of a write: RAM keeps 0x1.
    set_req(2, 32'h0001_0010, 4'hF, 1'b0, 32'h1234_5678);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    set_req(2, 32'd0, 4'd0, 1'b0, 32'd0);
    #1;
    chk("t6_valid", 32'(bus2.valid), 32'd1);
    chk("t6_rdata", bus2.rdata, 32'd0);
    chk("t6_fault", 32'(bus2.fault), 32'd0);
    chk("t6_gpio",  gpio2, 32'd0);
    @(negedge i_clk);
    access("t6_rd", 2, 32'h0001_0010, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'h0000_0001, 3, 0, q);

    // WAIT_STATES=0: one stall cycle per access.
    access("w0_wr",   0, 32'h0001_0020, 4'hF, 1'b0, 32'hCAFE_F00D, 0, 0, 1'b0, 32'd0, 1, 0, q);
    access("w0_rd_a", 0, 32'h0001_0020, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'hCAFE_F00D, 1, 0, q);
    access("w0_rd_b", 0, 32'h0001_0020, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'hCAFE_F00D, 1, 0, q);
    access("w0_bwr",  0, 32'h0001_0020, 4'b1000, 1'b0, 32'h1200_0000, 0, 0, 1'b1, 32'hCAFE_F00D, 1, 0, q);
    access("w0_brd",  0, 32'h0001_0020, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'h12FE_F00D, 1, 0, q);
    access("w0_oor",  0, 32'h0002_0020, 4'h0, 1'b1, 32'd0, 0, 0, 1'b1, 32'd0, 1, 1, q);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
